// File: rtl/piezo_sound_arbiter.sv
// Shares one piezo pin between horn, ESS alert, reverse beep and turn tick.
// Fixed-priority grant with a minimum play time, a silent gap between owners and a per-source tone.
module piezo_sound_arbiter #(
  parameter int HALF_HORN   = 12500,
  parameter int HALF_ESS    = 8333,
  parameter int HALF_REV    = 25000,
  parameter int HALF_TURN   = 50000,
  parameter int DIV_W       = 16,
  parameter int MIN_HOLD_MS = 50,
  parameter int GAP_MS      = 5
) (
  input  logic       CLK,
  input  logic       global_safe_rst,
  input  logic       tick_ms,
  input  logic       engine_on,
  input  logic       req_horn,
  input  logic       req_ess,
  input  logic       req_reverse,
  input  logic       req_turn,
  output logic [3:0] grant,
  output logic       busy,
  output logic       piezo_out
);

  localparam int HOLD_W = (MIN_HOLD_MS > 0) ? $clog2(MIN_HOLD_MS + 1) : 1;
  localparam int GAP_W  = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_MS);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_MS);

  // Terminal counts of the half-period divider, one per source
  localparam logic [DIV_W-1:0] TERM_HORN = DIV_W'(HALF_HORN - 1);
  localparam logic [DIV_W-1:0] TERM_ESS  = DIV_W'(HALF_ESS - 1);
  localparam logic [DIV_W-1:0] TERM_REV  = DIV_W'(HALF_REV - 1);
  localparam logic [DIV_W-1:0] TERM_TURN = DIV_W'(HALF_TURN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [1:0]        owner, owner_d;
  logic [DIV_W-1:0]  div_cnt, div_d, term_sel;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic              horn_q;
  logic [3:0]        grant_d;
  logic              busy_d, piezo_d;

  logic [3:0] r;
  logic [1:0] winner;
  logic       higher_req, own_req, horn_rise;

  always_comb begin
    r = {req_turn, req_reverse & engine_on, req_ess, req_horn};
    winner = 2'd3;
    if (r[2]) winner = 2'd2;
    if (r[1]) winner = 2'd1;
    if (r[0]) winner = 2'd0;
    own_req   = r[owner];
    horn_rise = req_horn & ~horn_q;
    case (owner)
      2'd0:    begin higher_req = 1'b0;      term_sel = TERM_HORN; end
      2'd1:    begin higher_req = r[0];      term_sel = TERM_ESS;  end
      2'd2:    begin higher_req = |r[1:0];   term_sel = TERM_REV;  end
      default: begin higher_req = |r[2:0];   term_sel = TERM_TURN; end
    endcase
  end

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_d = state;
    owner_d = owner;
    div_d   = div_cnt;
    hold_d  = hold_cnt;
    gap_d   = gap_cnt;
    grant_d = grant;
    busy_d  = busy;
    piezo_d = piezo_out;
    case (state)
      IDLE: begin
        if (r != 4'b0000) begin
          state_d = PLAY;
          owner_d = winner;
          grant_d = 4'b0001 << winner;
          busy_d  = 1'b1;
          div_d   = '0;
          hold_d  = '0;
          piezo_d = 1'b0;
        end
      end
      PLAY: begin
        if (div_cnt == term_sel) begin
          div_d   = '0;
          piezo_d = ~piezo_out;
        end else begin
          div_d = div_cnt + 1'b1;
        end
        if (tick_ms && (hold_cnt != HOLD_MAX)) hold_d = hold_cnt + 1'b1;
        // Horn preempts at once; everyone else must finish the minimum hold first
        if (((owner != 2'd0) && horn_rise) ||
            ((hold_cnt == HOLD_MAX) && (!own_req || higher_req))) begin
          state_d = GAP;
          grant_d = 4'b0000;
          piezo_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          hold_d  = '0;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_MAX) begin
          state_d = IDLE;
          gap_d   = '0;
          busy_d  = 1'b0;
        end else if (tick_ms) begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        piezo_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge global_safe_rst) begin
    if (global_safe_rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      div_cnt   <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      horn_q    <= 1'b0;
      grant     <= 4'b0000;
      busy      <= 1'b0;
      piezo_out <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      div_cnt   <= div_d;
      hold_cnt  <= hold_d;
      gap_cnt   <= gap_d;
      horn_q    <= req_horn;
      grant     <= grant_d;
      busy      <= busy_d;
      piezo_out <= piezo_d;
    end
  end

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Bench for piezo_sound_arbiter: directed scenarios plus random request traffic,
// every cycle compared against a time-based reference model of the arbiter.
module tb_piezo_sound_arbiter;

  localparam int H_HORN = 4, H_ESS = 5, H_REV = 6, H_TURN = 7;
  localparam int MIN_HOLD = 2, GAP_T = 1, TICK_PERIOD = 20;

  logic       CLK = 1'b0;
  logic       global_safe_rst;
  logic       tick_ms, engine_on;
  logic       req_horn, req_ess, req_reverse, req_turn;
  logic [3:0] grant;
  logic       busy, piezo_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: owner index (-1 = nobody), ms played, cycles played, gap progress
  int m_owner     = -1;
  bit m_gap       = 1'b0;
  int m_ticks     = 0;
  int m_cycles    = 0;
  int m_gap_ticks = 0;
  bit m_horn_prev = 1'b0;

  logic [3:0] exp_q[$];

  piezo_sound_arbiter #(
    .HALF_HORN(H_HORN), .HALF_ESS(H_ESS), .HALF_REV(H_REV), .HALF_TURN(H_TURN),
    .DIV_W(16), .MIN_HOLD_MS(MIN_HOLD), .GAP_MS(GAP_T)
  ) dut (
    .CLK(CLK), .global_safe_rst(global_safe_rst), .tick_ms(tick_ms), .engine_on(engine_on),
    .req_horn(req_horn), .req_ess(req_ess), .req_reverse(req_reverse), .req_turn(req_turn),
    .grant(grant), .busy(busy), .piezo_out(piezo_out)
  );

  always #5 CLK = ~CLK;

  function automatic int half_of(int s);
    case (s)
      0: return H_HORN;
      1: return H_ESS;
      2: return H_REV;
      default: return H_TURN;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock using the inputs as they stand before the edge
  task automatic model_step();
    logic [3:0] r;
    int w;
    bit higher;
    r = {req_turn, req_reverse & engine_on, req_ess, req_horn};
    if (global_safe_rst) begin
      m_owner = -1; m_gap = 1'b0; m_horn_prev = 1'b0;
      return;
    end
    if (m_owner >= 0) begin
      higher = 1'b0;
      for (int j = 0; j < m_owner; j++) if (r[j]) higher = 1'b1;
      if ((m_owner != 0 && req_horn && !m_horn_prev) ||
          (m_ticks >= MIN_HOLD && (!r[m_owner] || higher))) begin
        m_owner = -1; m_gap = 1'b1; m_gap_ticks = 0;
      end else begin
        m_cycles++;
        if (tick_ms && m_ticks < MIN_HOLD) m_ticks++;
      end
    end else if (m_gap) begin
      if (m_gap_ticks >= GAP_T) m_gap = 1'b0;
      else if (tick_ms) m_gap_ticks++;
    end else if (r != 4'b0000) begin
      w = 3;
      for (int i = 3; i >= 0; i--) if (r[i]) w = i;
      m_owner = w; m_ticks = 0; m_cycles = 0;
    end
    m_horn_prev = req_horn;
  endtask

  task automatic check_model();
    logic [3:0] g;
    logic p, b;
    g = 4'b0000;
    p = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      p = ((m_cycles / half_of(m_owner)) % 2) == 1;
    end
    b = (m_owner >= 0) || m_gap;
    check("model_grant", grant, g);
    check("model_busy", busy, b);
    check("model_piezo", piezo_out, p);
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    tick_ms = ((cyc % TICK_PERIOD) == 0);
    check_model();
  endtask

  // Run until the arbiter is idle, checking spacing between consecutive tone edges
  task automatic run_until_idle(string tag, int half);
    int n, last;
    logic p;
    n = 0; last = -1; p = piezo_out;
    while (busy === 1'b1 && n < 400) begin
      step();
      n++;
      if (piezo_out !== p && grant !== 4'b0000) begin
        if (last >= 0) check({tag, "_half_period"}, n - last, half);
        last = n;
      end
      p = piezo_out;
    end
    check({tag, "_idle_reached"}, busy, 1'b0);
  endtask

  initial begin
    logic [3:0] prev_g;
    int n, len;
    global_safe_rst = 1'b1;
    tick_ms = 1'b0; engine_on = 1'b0;
    req_horn = 1'b0; req_ess = 1'b0; req_reverse = 1'b0; req_turn = 1'b0;

    // Reset state
    step(); step();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_piezo", piezo_out, 1'b0);
    global_safe_rst = 1'b0;
    step();

    // One-cycle turn pulse
    req_turn = 1'b1;
    step();
    req_turn = 1'b0;
    check("turn_pulse_grant", grant, 4'b1000);
    check("turn_pulse_busy", busy, 1'b1);
    run_until_idle("turn_pulse", H_TURN);

    // ESS and turn together: ESS first, turn after ESS releases
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    prev_g = grant;
    req_ess = 1'b1; req_turn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i == 30) req_ess = 1'b0;
      step();
      if (grant !== prev_g && grant !== 4'b0000) begin
        if (exp_q.size() == 0) check("order_extra", grant, 4'b0000);
        else check("order", grant, exp_q.pop_front());
      end
      prev_g = grant;
    end
    check("order_done", exp_q.size(), 0);
    req_turn = 1'b0;
    run_until_idle("ess_turn", H_TURN);

    // Horn preempts the turn tick before its hold has elapsed
    req_turn = 1'b1;
    step();
    check("pre_turn_grant", grant, 4'b1000);
    req_horn = 1'b1;
    step();
    check("preempt_gap_grant", grant, 4'b0000);
    check("preempt_gap_busy", busy, 1'b1);
    n = 0;
    while (grant === 4'b0000 && n < 100) begin step(); n++; end
    check("horn_after_gap", grant, 4'b0001);
    req_horn = 1'b0; req_turn = 1'b0;
    run_until_idle("horn", H_HORN);

    // Reverse masked until the engine runs, then released when it stops
    req_reverse = 1'b1; engine_on = 1'b0;
    repeat (30) step();
    check("rev_masked", grant, 4'b0000);
    engine_on = 1'b1;
    step();
    check("rev_grant", grant, 4'b0100);
    engine_on = 1'b0;
    run_until_idle("rev", H_REV);
    req_reverse = 1'b0;
    step();

    // Horn held with turn: turn never gets the pin
    req_horn = 1'b1; req_turn = 1'b1;
    step();
    repeat (300) begin
      step();
      check("horn_starve", grant, 4'b0001);
    end
    req_horn = 1'b0; req_turn = 1'b0;
    run_until_idle("horn_hold", H_HORN);

    // Reset in the middle of a turn tick
    req_turn = 1'b1;
    repeat (12) step();
    check("pre_rst_grant", grant, 4'b1000);
    global_safe_rst = 1'b1;
    #1;
    check("async_rst_grant", grant, 4'b0000);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_piezo", piezo_out, 1'b0);
    repeat (3) step();
    req_turn = 1'b0;
    global_safe_rst = 1'b0;
    step();
    check("post_rst_idle", grant, 4'b0000);
    req_turn = 1'b1;
    step();
    check("post_rst_grant", grant, 4'b1000);
    req_turn = 1'b0;
    run_until_idle("post_rst", H_TURN);

    // Random request traffic against the model
    for (int b = 0; b < 70; b++) begin
      req_horn    = ($urandom_range(0, 5) == 0);
      req_ess     = ($urandom_range(0, 2) == 0);
      req_reverse = ($urandom_range(0, 1) == 0);
      req_turn    = ($urandom_range(0, 1) == 0);
      engine_on   = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(2, 60);
      repeat (len) step();
    end
    req_horn = 1'b0; req_ess = 1'b0; req_reverse = 1'b0; req_turn = 1'b0;
    repeat (120) step();
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
